txn_risk_scorer: RTL

TXN_RISK_SCORER -- requirements
Module: txn_risk_scorer

---
 rtl/txn_risk_pkg.sv | 65 ++++++
 rtl/txn_serial_div.sv | 61 ++++++
 rtl/txn_risk_scorer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/txn_risk_pkg.sv
// Shared definitions for the transaction risk scorer: method encodings, scoring FSM
// states, grading thresholds/scores and the grading helper functions.
// No ports (package).
package txn_risk_pkg;

  typedef enum logic [1:0] {
    MethStd    = 2'b00,
    MethTether = 2'b01,
    MethMonero = 2'b10,
    MethOther  = 2'b11
  } method_e;

  typedef enum logic [2:0] {
    StIdle,
    StDivM,
    StDivI,
    StDivV,
    StDivP,
    StGrade,
    StOut
  } state_e;

  // Threshold tables are ordered from the highest band to the lowest.
  localparam int MN = 3;
  localparam int unsigned MPct   [MN] = '{15, 10, 5};
  localparam int unsigned MScore [MN] = '{15, 10, 5};

  localparam int IN = 6;
  localparam int unsigned IHiPct [IN] = '{95, 90, 85, 80, 75, 70};
  localparam int unsigned ILoPct [IN] = '{5, 10, 15, 20, 25, 30};
  localparam int unsigned IScore [IN] = '{35, 30, 25, 20, 15, 10};

  localparam int VN = 5;
  localparam int unsigned VThresh [VN] = '{400000, 200000, 100000, 50000, 10000};
  localparam int unsigned VScore  [VN] = '{20, 17, 14, 10, 7};

  localparam int PN = 5;
  localparam int unsigned PGap   [PN] = '{3600, 1800, 720, 60, 1};
  localparam int unsigned PScore [PN] = '{30, 25, 20, 15, 5};

  // Each grader walks from the lowest band upward so the last hit is the highest band.
  function automatic logic [5:0] m_grade(input int unsigned pct, input logic priv);
    m_grade = '0;
    for (int k = MN - 1; k >= 0; k--) if (pct >= MPct[k]) m_grade = 6'(MScore[k]);
    if (priv) m_grade = 6'(MScore[0]);
  endfunction

  function automatic logic [5:0] i_grade(input int unsigned pct);
    i_grade = '0;
    for (int k = IN - 1; k >= 0; k--) begin
      if (pct >= IHiPct[k] || pct <= ILoPct[k]) i_grade = 6'(IScore[k]);
    end
  endfunction

  function automatic logic [5:0] v_grade(input int unsigned avg);
    v_grade = '0;
    for (int k = VN - 1; k >= 0; k--) if (avg >= VThresh[k]) v_grade = 6'(VScore[k]);
  endfunction

  function automatic logic [5:0] p_grade(input int unsigned gap);
    p_grade = '0;
    for (int k = PN - 1; k >= 0; k--) if (gap >= PGap[k]) p_grade = 6'(PScore[k]);
  endfunction

endpackage

// File: rtl/txn_serial_div.sv
// Serial restoring divider, one quotient bit per cycle, unsigned operands.
// Ports: clk, rst (async, active-high); i_start loads operands; after W step cycles
// o_done pulses for one cycle and o_quot holds the quotient until the next i_start.
// A zero divisor yields a zero quotient.
module txn_serial_div #(
  parameter int unsigned W = 38
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_quot
);

  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0]    r_rem;
  logic [W-1:0]    r_quo;
  logic [W-1:0]    r_div;
  logic [CntW-1:0] r_cnt;
  logic            r_zero;
  logic            r_done;
  logic [W:0]      w_shift;
  logic            w_ge;

  always_comb begin
    w_shift = {r_rem, r_quo[W-1]};
    w_ge    = w_shift >= {1'b0, r_div};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_zero <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
      r_zero <= (i_divisor == '0);
      r_cnt  <= CntW'(W);
      r_done <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rem  <= w_ge ? W'(w_shift - {1'b0, r_div}) : w_shift[W-1:0];
      r_quo  <= {r_quo[W-2:0], w_ge};
      r_cnt  <= r_cnt - CntW'(1);
      r_done <= (r_cnt == CntW'(1));
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_done = r_done;
  assign o_quot = r_zero ? '0 : r_quo;

endmodule

// File: rtl/txn_risk_scorer.sv
// Per-wallet transaction statistics with an on-demand risk score.
// Ports: clk, rst (async, active-high); txn_* accept transactions (valid/ready);
// score_req/score_wallet_in start scoring (score_ack pulse); score_valid/score_ready
// hand back score_wallet plus m/i/v/p sub-scores and their sum confidence_score.
// The scored wallet is cleared when its result is accepted.
module txn_risk_scorer
  import txn_risk_pkg::*;
#(
  parameter int unsigned N_WALLETS = 4,
  parameter int unsigned TS_W      = 16,
  parameter int unsigned VAL_W     = 30,
  parameter int unsigned CNT_W     = 8,
  localparam int unsigned ID_W     = $clog2(N_WALLETS),
  localparam int unsigned SUM_W    = VAL_W + CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             txn_valid,
  output logic             txn_ready,
  input  logic [ID_W-1:0]  txn_wallet,
  input  logic [TS_W-1:0]  time_stamp,
  input  logic             dir_in,
  input  logic [1:0]       method_field,
  input  logic [VAL_W-1:0] value,
  input  logic             score_req,
  input  logic [ID_W-1:0]  score_wallet_in,
  output logic             score_ack,
  output logic             score_valid,
  input  logic             score_ready,
  output logic [ID_W-1:0]  score_wallet,
  output logic [5:0]       m_score,
  output logic [5:0]       i_score,
  output logic [5:0]       v_score,
  output logic [5:0]       p_score,
  output logic [6:0]       confidence_score
);

  localparam int unsigned CtrW = $clog2(SUM_W + 1);

  logic [CNT_W-1:0] r_cnt       [N_WALLETS];
  logic [CNT_W-1:0] r_out_cnt   [N_WALLETS];
  logic [CNT_W-1:0] r_other_cnt [N_WALLETS];
  logic             r_priv      [N_WALLETS];
  logic [SUM_W-1:0] r_val_sum   [N_WALLETS];
  logic [TS_W-1:0]  r_first_ts  [N_WALLETS];
  logic [TS_W-1:0]  r_last_ts   [N_WALLETS];
  logic             r_active    [N_WALLETS];

  state_e           r_state, w_state_next;
  logic [CtrW-1:0]  r_ctr, w_ctr_next;
  logic [ID_W-1:0]  r_sel;
  logic [SUM_W-1:0] r_q_m, r_q_i, r_q_v;
  logic [5:0]       r_m, r_i, r_v, r_p;
  logic [6:0]       r_conf;

  logic             w_txn_fire, w_clear, w_cnt_nz, w_in_div, w_div_last;
  logic             w_div_start, w_div_done;
  logic [SUM_W-1:0] w_div_dividend, w_div_divisor, w_div_quot, w_cnt_ext;
  logic [TS_W-1:0]  w_gap;
  logic [5:0]       w_m, w_i, w_v, w_p;
  logic [6:0]       w_conf;

  // Only the wallet under scoring is frozen; all others keep accumulating.
  assign txn_ready   = !((r_state != StIdle) && (txn_wallet == r_sel));
  assign score_ack   = (r_state == StIdle) && score_req && !rst;
  // A saturated counter drops the whole transaction update.
  assign w_txn_fire  = txn_valid && txn_ready && !(&r_cnt[txn_wallet]);
  assign w_clear     = (r_state == StOut) && score_ready;
  assign w_cnt_ext   = SUM_W'(r_cnt[r_sel]);
  assign w_cnt_nz    = (r_cnt[r_sel] != '0);
  assign w_gap       = r_last_ts[r_sel] - r_first_ts[r_sel];
  assign w_in_div    = (r_state == StDivM) || (r_state == StDivI) ||
                       (r_state == StDivV) || (r_state == StDivP);
  assign w_div_last  = (r_ctr == CtrW'(SUM_W));
  // One load cycle plus SUM_W step cycles per DIV state; empty wallets skip the divider.
  assign w_div_start = w_in_div && (r_ctr == '0) && w_cnt_nz;

  always_comb begin
    w_state_next   = r_state;
    w_ctr_next     = (w_in_div && !w_div_last) ? r_ctr + CtrW'(1) : '0;
    w_div_dividend = '0;
    w_div_divisor  = w_cnt_ext;
    unique case (r_state)
      StIdle:  if (score_req) w_state_next = StDivM;
      StDivM: begin
        w_div_dividend = SUM_W'(r_other_cnt[r_sel]) * SUM_W'(100);
        if (w_div_last) w_state_next = StDivI;
      end
      StDivI: begin
        w_div_dividend = SUM_W'(r_out_cnt[r_sel]) * SUM_W'(100);
        if (w_div_last) w_state_next = StDivV;
      end
      StDivV: begin
        w_div_dividend = r_val_sum[r_sel];
        if (w_div_last) w_state_next = StDivP;
      end
      StDivP: begin
        w_div_dividend = SUM_W'(w_gap);
        w_div_divisor  = w_cnt_ext - SUM_W'(1);
        if (w_div_last) w_state_next = StGrade;
      end
      StGrade: w_state_next = StOut;
      StOut:   if (score_ready) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // The gap quotient is still on the divider output during GRADE.
  always_comb begin
    w_m    = m_grade(32'(r_q_m), r_priv[r_sel]);
    w_i    = i_grade(32'(r_q_i));
    w_v    = v_grade(32'(r_q_v));
    w_p    = p_grade(32'(w_div_quot));
    w_conf = {1'b0, w_m} + {1'b0, w_i} + {1'b0, w_v} + {1'b0, w_p};
  end

  txn_serial_div #(
    .W (SUM_W)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_div_dividend),
    .i_divisor  (w_div_divisor),
    .o_done     (w_div_done),
    .o_quot     (w_div_quot)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_ctr   <= '0;
      r_sel   <= '0;
      r_q_m   <= '0;
      r_q_i   <= '0;
      r_q_v   <= '0;
      r_m     <= '0;
      r_i     <= '0;
      r_v     <= '0;
      r_p     <= '0;
      r_conf  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ctr   <= w_ctr_next;
      if (score_ack) r_sel <= score_wallet_in;
      // Done arrives in the first cycle of the following state.
      if (w_div_done) begin
        case (r_state)
          StDivI:  r_q_m <= w_div_quot;
          StDivV:  r_q_i <= w_div_quot;
          StDivP:  r_q_v <= w_div_quot;
          default: ;
        endcase
      end
      if (r_state == StGrade) begin
        r_m    <= w_cnt_nz ? w_m : '0;
        r_i    <= w_cnt_nz ? w_i : '0;
        r_v    <= w_cnt_nz ? w_v : '0;
        r_p    <= w_cnt_nz ? w_p : '0;
        r_conf <= w_cnt_nz ? w_conf : '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_WALLETS; k++) begin
        r_cnt[k]       <= '0;
        r_out_cnt[k]   <= '0;
        r_other_cnt[k] <= '0;
        r_priv[k]      <= 1'b0;
        r_val_sum[k]   <= '0;
        r_first_ts[k]  <= '0;
        r_last_ts[k]   <= '0;
        r_active[k]    <= 1'b0;
      end
    end else begin
      if (w_txn_fire) begin
        r_cnt[txn_wallet] <= r_cnt[txn_wallet] + CNT_W'(1);
        if (!dir_in && !(&r_out_cnt[txn_wallet])) begin
          r_out_cnt[txn_wallet] <= r_out_cnt[txn_wallet] + CNT_W'(1);
        end
        if ((method_field == MethOther) && !(&r_other_cnt[txn_wallet])) begin
          r_other_cnt[txn_wallet] <= r_other_cnt[txn_wallet] + CNT_W'(1);
        end
        if ((method_field == MethTether) || (method_field == MethMonero)) begin
          r_priv[txn_wallet] <= 1'b1;
        end
        r_val_sum[txn_wallet] <= r_val_sum[txn_wallet] + SUM_W'(value);
        r_last_ts[txn_wallet] <= time_stamp;
        if (!r_active[txn_wallet]) r_first_ts[txn_wallet] <= time_stamp;
        r_active[txn_wallet] <= 1'b1;
      end
      // The scored wallet cannot accept a transaction in this cycle.
      if (w_clear) begin
        r_cnt[r_sel]       <= '0;
        r_out_cnt[r_sel]   <= '0;
        r_other_cnt[r_sel] <= '0;
        r_priv[r_sel]      <= 1'b0;
        r_val_sum[r_sel]   <= '0;
        r_first_ts[r_sel]  <= '0;
        r_last_ts[r_sel]   <= '0;
        r_active[r_sel]    <= 1'b0;
      end
    end
  end

  assign score_valid      = (r_state == StOut);
  assign score_wallet     = r_sel;
  assign m_score          = r_m;
  assign i_score          = r_i;
  assign v_score          = r_v;
  assign p_score          = r_p;
  assign confidence_score = r_conf;

endmodule
